// File: rtl/udl_cmd_gen.sv
`timescale 1ns/1ps
// udl_cmd_gen: debounced push-button front end driving up/dw/ld/D of the 16-bit udl counter.
// Auto-repeat of up/dw is built only when UDL_CMD_AUTO_REPEAT_EN is defined.
module udl_cmd_gen #(
    parameter int unsigned DB_CYCLES  = 16,
    parameter int unsigned REP_DELAY  = 64,
    parameter int unsigned REP_PERIOD = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        btn_up,
    input  logic        btn_dw,
    input  logic        btn_ld,
    input  logic [15:0] sw,
    input  logic        utc,
    input  logic        dtc,
    output logic        up,
    output logic        dw,
    output logic        ld,
    output logic [15:0] D
);
    localparam int unsigned DB_W = $clog2(DB_CYCLES);
    localparam int B_UP = 0;
    localparam int B_DW = 1;
    localparam int B_LD = 2;

    typedef enum logic [1:0] {IDLE, FIRST, DELAY, REPEAT} state_t;

    if (DB_CYCLES < 2 || REP_PERIOD < 2 || REP_DELAY < 1) begin : g_param_check
        $error("udl_cmd_gen: illegal parameter set");
    end

    logic [2:0]            btn, sync1, s, db, db_d, press, fall;
    logic [2:0][DB_W-1:0]  db_cnt;

    assign btn   = {btn_ld, btn_dw, btn_up};
    assign press = db & ~db_d;
    assign fall  = db_d & ~db;

    // NOTE: every register, counters included, sits in the async reset so a reset mid-press leaves no stale state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1  <= '0;
            s      <= '0;
            db     <= '0;
            db_d   <= '0;
            db_cnt <= '0;
        end else begin
            // NOTE: non-blocking assignments keep each stage reading last cycle's value, which is what makes this a shift chain.
            sync1 <= btn;
            s     <= sync1;
            db_d  <= db;
            for (int i = 0; i < 3; i++) begin
                if (s[i] == db[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_W'(DB_CYCLES - 1)) begin
                    db[i]     <= s[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DB_W'(1);
                end
            end
        end
    end

    state_t state, state_n;
    logic   dir, dir_n;      // 0: up, 1: dw
    logic   pulse, abort, ld_pend;

`ifdef UDL_CMD_AUTO_REPEAT_EN
    localparam int unsigned REP_MAX = (REP_DELAY > REP_PERIOD) ? REP_DELAY : REP_PERIOD;
    localparam int unsigned REP_W   = $clog2(REP_MAX);
    logic [REP_W-1:0] rep_cnt, rep_cnt_n;
`endif

    // A release, an opposing press or a load press kills the sequence in the very cycle it is seen.
    assign abort = (state != IDLE) &&
                   ((dir ? fall[B_DW] : fall[B_UP]) || (dir ? press[B_UP] : press[B_DW]) || press[B_LD]);

    always_comb begin
        // NOTE: defaults first so no path through the case leaves a signal unassigned and infers a latch.
        state_n = state;
        dir_n   = dir;
        pulse   = 1'b0;
`ifdef UDL_CMD_AUTO_REPEAT_EN
        rep_cnt_n = rep_cnt;
`endif
        case (state)
            IDLE: begin
                if (!press[B_LD]) begin
                    if (press[B_UP] && !db[B_DW]) begin
                        dir_n   = 1'b0;
                        state_n = FIRST;
                    end else if (press[B_DW] && !db[B_UP]) begin
                        dir_n   = 1'b1;
                        state_n = FIRST;
                    end
                end
            end
            FIRST: begin
                pulse = 1'b1;
`ifdef UDL_CMD_AUTO_REPEAT_EN
                state_n   = DELAY;
                rep_cnt_n = REP_W'(REP_DELAY - 1);
`else
                state_n = IDLE;
`endif
            end
`ifdef UDL_CMD_AUTO_REPEAT_EN
            DELAY: begin
                if (rep_cnt == '0) begin
                    pulse     = 1'b1;
                    state_n   = REPEAT;
                    rep_cnt_n = REP_W'(REP_PERIOD - 1);
                end else begin
                    rep_cnt_n = rep_cnt - REP_W'(1);
                end
            end
            REPEAT: begin
                if (rep_cnt == '0) begin
                    pulse     = 1'b1;
                    rep_cnt_n = REP_W'(REP_PERIOD - 1);
                end else begin
                    rep_cnt_n = rep_cnt - REP_W'(1);
                end
            end
`endif
            default: state_n = IDLE;
        endcase
        if (abort) begin
            state_n = IDLE;
            pulse   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            dir     <= 1'b0;
            ld_pend <= 1'b0;
            up      <= 1'b0;
            dw      <= 1'b0;
            ld      <= 1'b0;
            D       <= '0;
`ifdef UDL_CMD_AUTO_REPEAT_EN
            rep_cnt <= '0;
`endif
        end else begin
            state   <= state_n;
            dir     <= dir_n;
            ld_pend <= press[B_LD];
            ld      <= ld_pend;
            if (press[B_LD]) begin
                D <= sw;
            end
            // Saturation masks only the output; the schedule keeps running.
            up <= pulse && !dir && !utc && !ld_pend;
            dw <= pulse &&  dir && !dtc && !ld_pend;
`ifdef UDL_CMD_AUTO_REPEAT_EN
            rep_cnt <= rep_cnt_n;
`endif
        end
    end
endmodule

// File: tb/tb_udl_cmd_gen.sv
`timescale 1ns/1ps
// tb_udl_cmd_gen: scoreboard of expected command pulses plus a load-value vector table.
module tb_udl_cmd_gen;
    localparam int DB  = 4;
    localparam int RD  = 8;
    localparam int RP  = 3;
    localparam int LAT = 2 + DB + 2;
    localparam int K_UP = 0;
    localparam int K_DW = 1;
    localparam int K_LD = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        btn_up, btn_dw, btn_ld;
    logic [15:0] sw;
    logic        utc, dtc;
    logic        up, dw, ld;
    logic [15:0] D;

    udl_cmd_gen #(.DB_CYCLES(DB), .REP_DELAY(RD), .REP_PERIOD(RP)) dut (
        .clk(clk), .rst_n(rst_n), .btn_up(btn_up), .btn_dw(btn_dw), .btn_ld(btn_ld),
        .sw(sw), .utc(utc), .dtc(dtc), .up(up), .dw(dw), .ld(ld), .D(D)
    );

    always #5 clk = ~clk;

    typedef struct { int cyc; int kind; } exp_t;
    typedef struct { logic [15:0] sw; logic [15:0] sw_after; logic [15:0] d_exp; } ld_vec_t;

    exp_t    sb[$];
    exp_t    mon_exp;
    int      mon_kind;
    int      checks = 0;
    int      failures = 0;
    int      cyc = 0;
    int      k, k2;
    ld_vec_t ld_tbl [3];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Outputs are sampled 1 ns after the edge; stimulus moves 2 ns after the edge.
    always @(posedge clk) begin
        #1;
        if (up === 1'b1 || dw === 1'b1 || ld === 1'b1) begin
            mon_kind = (ld === 1'b1) ? K_LD : ((dw === 1'b1) ? K_DW : K_UP);
            check("one_hot_cmd", 32'(up) + 32'(dw) + 32'(ld), 32'd1);
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_pulse: got kind %0d at cycle %0d expected no pulse", mon_kind, cyc);
            end else begin
                mon_exp = sb.pop_front();
                check("pulse_kind", mon_kind, mon_exp.kind);
                check("pulse_cycle", cyc, mon_exp.cyc);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Expected pulse edges for a button rising after edge k_rise; edges > cutoff are never
    // issued and edges in (sup_lo, sup_hi] are masked by saturation.
    task automatic gen(input int kind, input int k_rise, input int cutoff, input int sup_lo, input int sup_hi);
        int e;
        e = k_rise + LAT;
        while (e <= cutoff) begin
            if (!(e > sup_lo && e <= sup_hi)) sb.push_back('{e, kind});
`ifdef UDL_CMD_AUTO_REPEAT_EN
            e += (e == k_rise + LAT) ? RD : RP;
`else
            break;
`endif
        end
    endtask

    task automatic settle(input string name, input int n);
        tick(n);
        check(name, sb.size(), 0);
        sb.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        ld_tbl[0] = '{16'hA5C3, 16'h0F0F, 16'hA5C3};
        ld_tbl[1] = '{16'hFFFF, 16'h0000, 16'hFFFF};
        ld_tbl[2] = '{16'h1234, 16'hEDCB, 16'h1234};

        rst_n = 1'b0; btn_up = 1'b0; btn_dw = 1'b0; btn_ld = 1'b0;
        sw = 16'h0000; utc = 1'b0; dtc = 1'b0;
        tick(3);
        check("reset_up", up, 1'b0);
        check("reset_dw", dw, 1'b0);
        check("reset_ld", ld, 1'b0);
        check("reset_D", D, 16'h0000);
        rst_n = 1'b1;
        tick(5);

        // Glitch of 3 synchronized cycles is filtered.
        btn_up = 1'b1;
        tick(3);
        btn_up = 1'b0;
        settle("glitch_no_pulse", 30);

        // Hold up 40 cycles.
        k = cyc;
        gen(K_UP, k, k + 40 + DB + 2, -1, -1);
        btn_up = 1'b1;
        tick(40);
        btn_up = 1'b0;
        settle("hold_up_drained", 40);

        // Short dw hold.
        k = cyc;
        gen(K_DW, k, k + 12 + DB + 2, -1, -1);
        btn_dw = 1'b1;
        tick(12);
        btn_dw = 1'b0;
        settle("hold_dw_drained", 30);

        // dw held at the zero limit: nothing issued.
        k = cyc;
        dtc = 1'b1;
        btn_dw = 1'b1;
        tick(20);
        btn_dw = 1'b0;
        tick(15);
        dtc = 1'b0;
        settle("dtc_saturated", 10);

        // up held with utc high for the first 20 cycles.
        k = cyc;
        gen(K_UP, k, k + 40 + DB + 2, k, k + 20);
        utc = 1'b1;
        btn_up = 1'b1;
        tick(20);
        utc = 1'b0;
        tick(20);
        btn_up = 1'b0;
        settle("utc_saturation", 40);

        // dw pressed while up repeats: repeat stops, no dw.
        k = cyc;
        gen(K_UP, k, k + 20 + DB + 2, -1, -1);
        btn_up = 1'b1;
        tick(20);
        btn_dw = 1'b1;
        tick(10);
        btn_up = 1'b0;
        btn_dw = 1'b0;
        settle("interlock", 40);

        // Load vectors: D valid one cycle before ld, held after sw moves.
        for (int i = 0; i < 3; i++) begin
            sw = ld_tbl[i].sw;
            k = cyc;
            sb.push_back('{k + LAT, K_LD});
            btn_ld = 1'b1;
            tick(LAT - 1);
            check("ld_D_before_pulse", D, ld_tbl[i].d_exp);
            check("ld_low_before_pulse", ld, 1'b0);
            tick(3);
            btn_ld = 1'b0;
            sw = ld_tbl[i].sw_after;
            settle("ld_drained", 20);
            check("ld_D_held", D, ld_tbl[i].d_exp);
        end

        // Reset asserted mid-cycle while up is high and D is loaded.
        k = cyc;
        gen(K_UP, k, k + LAT, -1, -1);
        btn_up = 1'b1;
        tick(LAT);
        #3;
        rst_n = 1'b0;
        #1;
        check("midrst_up", up, 1'b0);
        check("midrst_ld", ld, 1'b0);
        check("midrst_D", D, 16'h0000);
        check("midrst_sb", sb.size(), 0);
        sb.delete();
        tick(2);

        // Button held through reset release yields a fresh press.
        rst_n = 1'b1;
        k2 = cyc;
        gen(K_UP, k2, k2 + 6 + DB + 2, -1, -1);
        tick(6);
        btn_up = 1'b0;
        settle("held_through_reset", 30);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
